// File: rtl/line_clear_ctrl_pkg.sv
// Package tetris_pkg: shared playfield dimensions, grid/state types and
// scoring helpers for the line-clear sequencer.
//   ROWS/COLS   playfield size; row 0 is the top row, row ROWS-1 the bottom
//   SCORE_W     score width; the score saturates at SCORE_MAX
//   grid_t      whole playfield, one packed row of COLS bits per row index
//   state_t     sequencer states
//   line_pts    points awarded for a given number of rows removed at once
//   level_of    level derived from total lines (used with LINE_CLEAR_LEVEL_EN)
package tetris_pkg;

  localparam int ROWS    = 22;
  localparam int COLS    = 10;
  localparam int SCORE_W = 8;
  localparam int ROW_W   = $clog2(ROWS);
  localparam int CNT_W   = 5;
  localparam int LVL_W   = 4;
  localparam int TOT_W   = 8;

  localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

  typedef logic [COLS-1:0]            row_t;
  typedef logic [ROWS-1:0][COLS-1:0]  grid_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  function automatic logic [3:0] line_pts(input logic [CNT_W-1:0] n);
    logic [3:0] p;
    case (n)
      5'd0:    p = 4'd0;
      5'd1:    p = 4'd1;
      5'd2:    p = 4'd3;
      5'd3:    p = 4'd5;
      default: p = 4'd8;
    endcase
    return p;
  endfunction

  // Ten lines per level, capped at level 9.
  function automatic logic [LVL_W-1:0] level_of(input logic [TOT_W-1:0] t);
    logic [TOT_W-1:0] q;
    q = t / TOT_W'(10);
    if (q > TOT_W'(9)) q = TOT_W'(9);
    return q[LVL_W-1:0];
  endfunction

endpackage

// File: rtl/line_clear_ctrl_if.sv
// Interface between the game FSM / display side and the line-clear sequencer.
//   master: game side, drives start/clear/grid_in, observes results
//   slave : sequencer, consumes requests, drives grid_out/busy/done/
//           lines_cleared/score/level
interface line_clear_ctrl_if;

  logic                          start;
  logic                          clear;
  tetris_pkg::grid_t             grid_in;
  tetris_pkg::grid_t             grid_out;
  logic                          busy;
  logic                          done;
  logic [tetris_pkg::CNT_W-1:0]  lines_cleared;
  logic [tetris_pkg::SCORE_W-1:0] score;
  logic [tetris_pkg::LVL_W-1:0]  level;

  modport master (
    output start, clear, grid_in,
    input  grid_out, busy, done, lines_cleared, score, level
  );

  modport slave (
    input  start, clear, grid_in,
    output grid_out, busy, done, lines_cleared, score, level
  );

endinterface

// File: rtl/line_clear_ctrl_scorer.sv
// line_clear_scorer: combinational next-score computation.
//   line_cnt   rows removed by the operation being completed
//   score_cur  current score
//   level_cur  level before this operation (0 when levels are disabled)
//   score_nxt  score_cur + pts(line_cnt)*(level_cur+1), saturated at SCORE_MAX
module line_clear_scorer
  import tetris_pkg::*;
(
  input  logic [CNT_W-1:0]   line_cnt,
  input  logic [SCORE_W-1:0] score_cur,
  input  logic [LVL_W-1:0]   level_cur,
  output logic [SCORE_W-1:0] score_nxt
);

  localparam int SUM_W = SCORE_W + 8;

  logic [7:0]       inc;
  logic [SUM_W-1:0] sum;

  always_comb begin
    // pts <= 8 and level+1 <= 16, so the increment fits in 8 bits.
    inc = 8'(line_pts(line_cnt)) * (8'(level_cur) + 8'd1);
    sum = SUM_W'(score_cur) + SUM_W'(inc);
    if (sum > SUM_W'(SCORE_MAX)) begin
      score_nxt = SCORE_MAX;
    end else begin
      score_nxt = sum[SCORE_W-1:0];
    end
  end

endmodule

// File: rtl/line_clear_ctrl.sv
// line_clear_ctrl: post-lock line-clear sequencer.
// Latches the playfield on start, scans rows bottom to top, removes each full
// row by shifting everything above it down one row, then publishes the
// compacted grid, the number of rows removed and the updated score.
//   clk, rst_n  clock; asynchronous active-low reset
//   bus.slave   start/clear/grid_in in; grid_out/busy/done/lines_cleared/
//               score/level out
// Optional macro LINE_CLEAR_LEVEL_EN: adds a saturating total-lines counter,
// level = min(total/10, 9), and scales the score increment by (level+1).
// Without it level is tied to 0.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for start; outputs hold
// SCAN  | test working row row_idx; one row per cycle, bottom to top
// SHIFT | drop rows [row_idx-1:0] into [row_idx:1], zero row 0, count line
// DONE  | one-cycle done pulse; results were registered on entry
module line_clear_ctrl
  import tetris_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  line_clear_ctrl_if.slave  bus
);

  state_t             state_q,    state_d;
  logic [ROW_W-1:0]   row_idx_q,  row_idx_d;
  logic [CNT_W-1:0]   cnt_q,      cnt_d;
  grid_t              work_q,     work_d;
  grid_t              grid_out_q, grid_out_d;
  logic [CNT_W-1:0]   lines_q,    lines_d;
  logic [SCORE_W-1:0] score_q,    score_d;
  logic               done_q,     done_d;
  logic [SCORE_W-1:0] score_nxt;
  logic [LVL_W-1:0]   level_cur;

`ifdef LINE_CLEAR_LEVEL_EN
  logic [TOT_W-1:0]   total_q,    total_d;
  logic [LVL_W-1:0]   level_q,    level_d;
  logic [TOT_W:0]     total_sum;
  logic [TOT_W-1:0]   total_sat;

  assign level_cur = level_q;

  always_comb begin
    total_sum = {1'b0, total_q} + (TOT_W+1)'(cnt_q);
    total_sat = total_sum[TOT_W] ? '1 : total_sum[TOT_W-1:0];
  end
`else
  assign level_cur = '0;
`endif

  line_clear_scorer u_scorer (
    .line_cnt  (cnt_q),
    .score_cur (score_q),
    .level_cur (level_cur),
    .score_nxt (score_nxt)
  );

  always_comb begin
    state_d    = state_q;
    row_idx_d  = row_idx_q;
    cnt_d      = cnt_q;
    work_d     = work_q;
    grid_out_d = grid_out_q;
    lines_d    = lines_q;
    score_d    = score_q;
    done_d     = 1'b0;
`ifdef LINE_CLEAR_LEVEL_EN
    total_d    = total_q;
    level_d    = level_q;
`endif

    if (bus.clear) begin
      // New game wins over everything, including a pending DONE entry.
      state_d = IDLE;
      score_d = '0;
`ifdef LINE_CLEAR_LEVEL_EN
      total_d = '0;
      level_d = '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            work_d    = bus.grid_in;
            row_idx_d = ROW_W'(ROWS - 1);
            cnt_d     = '0;
            state_d   = SCAN;
          end
        end

        SCAN: begin
          if (&work_q[row_idx_q]) begin
            state_d = SHIFT;
          end else if (row_idx_q == '0) begin
            // Results are registered on DONE entry so they are valid
            // in the same cycle as the done pulse.
            state_d    = DONE;
            done_d     = 1'b1;
            grid_out_d = work_q;
            lines_d    = cnt_q;
            score_d    = score_nxt;
`ifdef LINE_CLEAR_LEVEL_EN
            total_d    = total_sat;
            level_d    = level_of(total_sat);
`endif
          end else begin
            row_idx_d = row_idx_q - 1'b1;
          end
        end

        SHIFT: begin
          // row_idx is kept so the row that just dropped in is re-tested.
          for (int r = 0; r < ROWS; r++) begin
            if (r == 0) begin
              work_d[r] = '0;
            end else if (ROW_W'(r) <= row_idx_q) begin
              work_d[r] = work_q[r-1];
            end
          end
          cnt_d   = cnt_q + 1'b1;
          state_d = SCAN;
        end

        DONE: begin
          state_d = IDLE;
        end

        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      row_idx_q  <= ROW_W'(ROWS - 1);
      cnt_q      <= '0;
      work_q     <= '0;
      grid_out_q <= '0;
      lines_q    <= '0;
      score_q    <= '0;
      done_q     <= 1'b0;
`ifdef LINE_CLEAR_LEVEL_EN
      total_q    <= '0;
      level_q    <= '0;
`endif
    end else begin
      state_q    <= state_d;
      row_idx_q  <= row_idx_d;
      cnt_q      <= cnt_d;
      work_q     <= work_d;
      grid_out_q <= grid_out_d;
      lines_q    <= lines_d;
      score_q    <= score_d;
      done_q     <= done_d;
`ifdef LINE_CLEAR_LEVEL_EN
      total_q    <= total_d;
      level_q    <= level_d;
`endif
    end
  end

  assign bus.busy          = (state_q != IDLE);
  assign bus.done          = done_q;
  assign bus.grid_out      = grid_out_q;
  assign bus.lines_cleared = lines_q;
  assign bus.score         = score_q;
  assign bus.level         = level_cur;

endmodule

// File: tb/tb_line_clear_ctrl.sv
// Testbench for line_clear_ctrl. A behavioural model predicts each
// operation's result by filtering full rows out of the grid, and its timing
// from the rows + 2*lines latency rule; a compare process checks every DUT
// output after every clock edge. Honours LINE_CLEAR_LEVEL_EN like the design.
module tb_line_clear_ctrl;
  import tetris_pkg::*;

  typedef logic [ROWS*COLS-1:0] wide_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  line_clear_ctrl_if bus();

  line_clear_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;
  int edge_n = 0;
  bit chk_en = 1'b0;

  // Model state
  bit    op_active    = 1'b0;
  int    op_start_edge;
  int    op_done_edge;
  grid_t op_grid;
  int    op_lines;
  int    clear_edge   = -1;
  grid_t exp_grid_out = '0;
  int    exp_lines    = 0;
  int    exp_score    = 0;
  int    exp_level    = 0;
  int    exp_total    = 0;
  int    pts_tab[5]   = '{0, 1, 3, 5, 8};
  localparam int SMAX = (1 << SCORE_W) - 1;

  bit m_done;
  bit m_busy;
  int m_inc;

  task automatic chk(input string nm, input wide_t act, input wide_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", nm, act, exp, edge_n);
    end
  endtask

  // Compacted playfield: keep non-full rows in order, stack them at the bottom.
  function automatic grid_t compact(input grid_t g, output int l);
    grid_t o = '0;
    int k = ROWS - 1;
    l = 0;
    for (int r = ROWS - 1; r >= 0; r--) begin
      if (g[r] == {COLS{1'b1}}) l++;
      else begin
        o[k] = g[r];
        k--;
      end
    end
    return o;
  endfunction

  // Compare process: after every edge, advance the model and check outputs.
  always begin
    @(posedge clk);
    #1;
    edge_n++;
    if (chk_en) begin
      if (edge_n == clear_edge) begin
        op_active = 1'b0;
        exp_score = 0;
        exp_level = 0;
        exp_total = 0;
      end
      m_done = 1'b0;
      if (op_active) begin
        if (edge_n == op_done_edge) begin
          m_done       = 1'b1;
          exp_grid_out = op_grid;
          exp_lines    = op_lines;
          m_inc        = pts_tab[(op_lines > 4) ? 4 : op_lines];
`ifdef LINE_CLEAR_LEVEL_EN
          m_inc        = m_inc * (exp_level + 1);
          exp_total    = (exp_total + op_lines > 255) ? 255 : exp_total + op_lines;
          exp_level    = (exp_total / 10 > 9) ? 9 : exp_total / 10;
`endif
          exp_score    = (exp_score + m_inc > SMAX) ? SMAX : exp_score + m_inc;
        end else if (edge_n > op_done_edge) begin
          op_active = 1'b0;
        end
      end
      m_busy = op_active && (edge_n >= op_start_edge);
      chk("busy",          wide_t'(bus.busy),          wide_t'(m_busy));
      chk("done",          wide_t'(bus.done),          wide_t'(m_done));
      chk("grid_out",      wide_t'(bus.grid_out),      wide_t'(exp_grid_out));
      chk("lines_cleared", wide_t'(bus.lines_cleared), wide_t'(exp_lines));
      chk("score",         wide_t'(bus.score),         wide_t'(exp_score));
      chk("level",         wide_t'(bus.level),         wide_t'(exp_level));
    end
  end

  // Called at a negedge; the request is sampled at the next edge.
  task automatic start_op(input grid_t g);
    int    l;
    grid_t c;
    bus.grid_in = g;
    bus.start   = 1'b1;
    if (!op_active && !bus.clear) begin
      c             = compact(g, l);
      op_active     = 1'b1;
      op_start_edge = edge_n + 1;
      op_done_edge  = edge_n + 1 + ROWS + 2 * l;
      op_grid       = c;
      op_lines      = l;
    end
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic pulse_clear();
    bus.clear  = 1'b1;
    clear_edge = edge_n + 1;
    @(negedge clk);
    bus.clear  = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (op_active && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (op_active) begin
      chk("wait_idle_timeout", wide_t'(1), wide_t'(0));
      op_active = 1'b0;
    end
  endtask

  // Runs one operation and checks the start-to-done edge count.
  task automatic run_lat(input grid_t g, input int exp_lat);
    int e0;
    int lat = -1;
    e0 = edge_n + 1;
    start_op(g);
    for (int n = 0; n < 200; n++) begin
      if (bus.done) begin
        lat = edge_n - e0;
        break;
      end
      @(negedge clk);
    end
    chk("latency", wide_t'(lat), wide_t'(exp_lat));
    wait_idle();
  endtask

  function automatic grid_t rand_grid();
    grid_t g;
    for (int r = 0; r < ROWS; r++) begin
      if ($urandom_range(0, 2) == 0) g[r] = '1;
      else g[r] = COLS'($urandom);
    end
    return g;
  endfunction

  grid_t g0, g1, g2, g3, ge;
  int    rsel;

  initial begin
    rst_n       = 1'b0;
    bus.start   = 1'b0;
    bus.clear   = 1'b0;
    bus.grid_in = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    chk("reset_busy",  wide_t'(bus.busy),  wide_t'(0));
    chk("reset_score", wide_t'(bus.score), wide_t'(0));
    chk("reset_grid",  wide_t'(bus.grid_out), wide_t'(0));
    chk_en = 1'b1;
    @(negedge clk);

    // Empty grid
    g0 = '0;
    g0[5] = 10'b0011001100;
    run_lat(g0, 22);
    chk("empty_lines", wide_t'(bus.lines_cleared), wide_t'(0));
    chk("empty_grid",  wide_t'(bus.grid_out),      wide_t'(g0));
    chk("empty_score", wide_t'(bus.score),         wide_t'(0));

    // One line
    g1 = '0;
    g1[21] = '1;
    g1[20] = 10'b0000000001;
    run_lat(g1, 24);
    chk("one_lines", wide_t'(bus.lines_cleared), wide_t'(1));
    chk("one_row21", wide_t'(bus.grid_out[21]),  wide_t'(10'b0000000001));
    chk("one_row20", wide_t'(bus.grid_out[20]),  wide_t'(0));
    chk("one_score", wide_t'(bus.score),         wide_t'(1));

    // Four lines
    g2 = '0;
    for (int r = 18; r < 22; r++) g2[r] = '1;
    g2[17] = 10'b1010101010;
    ge = '0;
    ge[21] = 10'b1010101010;
    run_lat(g2, 30);
    chk("four_lines", wide_t'(bus.lines_cleared), wide_t'(4));
    chk("four_grid",  wide_t'(bus.grid_out),      wide_t'(ge));
    chk("four_score", wide_t'(bus.score),         wide_t'(9));

    // Two non-adjacent lines
    g3 = '0;
    g3[21] = '1;
    g3[19] = '1;
    g3[20] = 10'b1111111110;
    run_lat(g3, 26);
    chk("two_lines", wide_t'(bus.lines_cleared), wide_t'(2));
    chk("two_row21", wide_t'(bus.grid_out[21]),  wide_t'(10'b1111111110));
    chk("two_score", wide_t'(bus.score),         wide_t'(12));

    // Ignored start in SCAN, then clear sampled on edge 5 of the scan
    start_op(g2);
    @(negedge clk);
    start_op(g1);
    repeat (2) @(negedge clk);
    pulse_clear();
    chk("clear_busy",  wide_t'(bus.busy),  wide_t'(0));
    chk("clear_score", wide_t'(bus.score), wide_t'(0));
    chk("clear_lines_hold", wide_t'(bus.lines_cleared), wide_t'(2));
    repeat (30) @(negedge clk);

    // Repeated four-line clears up to saturation
    for (int k = 1; k <= 32; k++) begin
      start_op(g2);
      wait_idle();
`ifdef LINE_CLEAR_LEVEL_EN
      if (k == 3) chk("lvl_after3", wide_t'(bus.level), wide_t'(1));
      if (k == 4) chk("lvl_score4", wide_t'(bus.score), wide_t'(40));
`else
      if (k == 31) chk("sat_248", wide_t'(bus.score), wide_t'(248));
`endif
    end
    chk("sat_255", wide_t'(bus.score), wide_t'(255));

    // Randomized operations
    pulse_clear();
    for (int n = 0; n < 30; n++) begin
      start_op(rand_grid());
      rsel = $urandom_range(0, 5);
      if (rsel == 0) begin
        repeat ($urandom_range(0, 40)) @(negedge clk);
        pulse_clear();
      end else if (rsel == 1) begin
        repeat ($urandom_range(0, 20)) @(negedge clk);
        start_op(rand_grid());
      end
      wait_idle();
    end

    // Asynchronous reset in the middle of a scan
    start_op(g2);
    repeat (6) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_busy",  wide_t'(bus.busy),          wide_t'(0));
    chk("arst_done",  wide_t'(bus.done),          wide_t'(0));
    chk("arst_grid",  wide_t'(bus.grid_out),      wide_t'(0));
    chk("arst_lines", wide_t'(bus.lines_cleared), wide_t'(0));
    chk("arst_score", wide_t'(bus.score),         wide_t'(0));
    chk("arst_level", wide_t'(bus.level),         wide_t'(0));
    op_active    = 1'b0;
    clear_edge   = -1;
    exp_grid_out = '0;
    exp_lines    = 0;
    exp_score    = 0;
    exp_level    = 0;
    exp_total    = 0;
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    run_lat(g1, 24);
    chk("post_rst_score", wide_t'(bus.score), wide_t'(1));

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/line_clear_ctrl.md
Name: line_clear_ctrl

Overview:
Sequencer that runs after a piece locks into the Tetris playfield. On a start pulse it latches the stored grid and scans rows from bottom to top. Each full row is removed and the rows above it shift down. When the scan ends it returns the compacted grid, the number of lines cleared, and an updated saturating score. It sits between the game FSM (start/clear) and the grid renderer and score display (grid_out, score).

Parameters:
ROWS, 22, playfield rows; row 0 is the top row, row ROWS-1 is the bottom row
COLS, 10, playfield columns
SCORE_W, 8, score width in bits; the score saturates at 2^SCORE_W-1

Ports:
clk  input  1  system clock (one clock domain)
rst_n  input  1  reset, asynchronous and active-low
start  input  1  one-cycle request; sampled only in IDLE
clear  input  1  synchronous new-game: zero score/level, abort any operation
grid_in  input  [ROWS-1:0][COLS-1:0]  stored playfield, sampled on the cycle start is accepted
grid_out  output  [ROWS-1:0][COLS-1:0]  compacted playfield, valid from done onward
busy  output  1  high in SCAN, SHIFT and DONE
done  output  1  one-cycle pulse when the result is valid
lines_cleared  output  5  rows removed by the last completed operation
score  output  SCORE_W  running score
level  output  4  level counter (0 when the optional feature is off)

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE; grid_out=0, busy=0, done=0, lines_cleared=0, score=0, level=0, internal row index=ROWS-1, line count=0.
- A row is full when all COLS bits are 1.
- IDLE: when start=1 and clear=0, latch grid_in into the working grid, set row_idx=ROWS-1, zero the line count, go to SCAN. Otherwise hold all outputs.
- SCAN (one row per cycle):
  - Working row row_idx full -> go to SHIFT.
  - Not full and row_idx=0 -> go to DONE.
  - Otherwise row_idx-- and stay in SCAN.
- SHIFT (1 cycle):
  - rows[row_idx:1] <= rows[row_idx-1:0]; row 0 <= 0.
  - Line count +1 (5-bit, cannot overflow for ROWS<=31).
  - Return to SCAN with the same row_idx, so the shifted-in row is re-checked.
  - If row_idx=0 the cycle only clears row 0.
- DONE (1 cycle): done=1; grid_out <= working grid; lines_cleared <= line count; score <= sat(score + pts); go to IDLE.
- Points table, indexed by line count: 0->0, 1->1, 2->3, 3->5, 4 or more->8.
- Score addition saturates at 2^SCORE_W-1; it never wraps.
- Latency: with L lines cleared, done is high in the cycle following the 22+2L-th clock edge after the start-sampling edge (ROWS+2L in general).
- start outside IDLE is ignored; there is no queueing.
- clear=1 (any state): next edge gives state=IDLE, score=0, level=0, done=0. grid_out and lines_cleared hold. clear has priority over start and over DONE.
- busy is combinational from state; done is registered and high only in DONE.

Optional Feature:
Macro LINE_CLEAR_LEVEL_EN.
- Defined:
  - A saturating 8-bit total-lines counter accumulates the line count at DONE.
  - level = min(total_lines/10, 9), updated at DONE.
  - The score increment is pts*(level+1), using the level value from before this operation, and is still saturating.
  - clear zeroes total_lines and level.
- Not defined: level is tied to 0, the increment is pts, and no total-lines register exists.

Decomposition:
- Package tetris_pkg holds:
  - ROWS/COLS constants
  - typedef grid_t (logic [ROWS-1:0][COLS-1:0])
  - state enum {IDLE, SCAN, SHIFT, DONE}
  - the points lookup function
- One sub-module, line_clear_scorer: purely combinational; inputs line count, current score and level; output is the saturated next score.

Test Plan:
- Empty grid, start -> done at edge 22, lines_cleared=0, grid_out=grid_in, score=0.
- Row 21 full, row 20=10'b0000000001 -> done at edge 24, lines_cleared=1, grid_out row21=10'b0000000001, row20=0, score=1.
- Rows 18-21 full, row 17=10'b1010101010 -> done at edge 30, lines_cleared=4, row21=10'b1010101010, rows 0-20=0, score +8.
- Rows 21 and 19 full, row 20=10'b1111111110 -> lines_cleared=2, row21=10'b1111111110, score +3.
- 32 consecutive four-line clears -> score reaches 248 then saturates at 255. With the macro on, the level becomes 1 after the 3rd clear and the increment becomes 16.
- Assert clear at edge 5 of a scan -> busy low next cycle, no done pulse, score=0. Pulse start during SCAN -> ignored. Drop rst_n mid-scan -> all outputs 0 with no clock edge.
